seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 16: clock cycles per digit slot; legal values are 2 to 2^20.
REQ-002 Parameter BLINK_DIV, default 32: number of complete scan frames per blink half-period; legal values are 1 to 2^16.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port disp_num, input, 32 bits: display value, 8 hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i.
REQ-006 Port load, input, 1 bit: capture strobe for disp_num, point and blink_en.
REQ-007 Port point, input, 8 bits: decimal-point enable per digit, 1 = lit.
REQ-008 Port blink_en, input, 8 bits: blink enable per digit, 1 = blinks.
REQ-009 Port zero_blank, input, 1 bit: leading-zero suppression enable; sampled live, not captured by load.
REQ-010 Port an, output, 8 bits: digit enables, active-low, registered.
REQ-011 Port seg, output, 8 bits: segment drives, active-low, registered; seg[0]=a .. seg[6]=g, seg[7]=dp.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse per completed 8-digit frame, registered.

Function
REQ-013 Shadow registers for value, point and blink SHALL load from disp_num, point and blink_en on any edge with load=1, and hold otherwise.
REQ-014 A load mid-scan SHALL NOT reset cnt or idx; the new data SHALL appear on the next registered output update.
REQ-015 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; at cnt=SCAN_DIV-1, idx (3 bits) SHALL advance by 1, wrapping 7 to 0.
REQ-016 Registered outputs SHALL be computed from the current cnt, idx and shadow state, so they lag the counters by exactly one cycle.
REQ-017 Ghost suppression: when cnt=0, the next an and seg SHALL both be 8'hFF, so each slot is 1 dark cycle followed by SCAN_DIV-1 lit cycles.
REQ-018 Lit cycle: an SHALL be ~(8'b1 << idx).
REQ-019 Lit cycle: seg[6:0] SHALL be the hex decode of nibble idx.
REQ-020 Lit cycle: seg[7] SHALL be ~point_shadow[idx].
REQ-021 Hex decode SHALL use standard gfedcba patterns, active-low; for example 0 -> 7'h40, 5 -> 7'h12, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
REQ-022 A frame counter SHALL increment when idx wraps 7 to 0.
REQ-023 When the frame counter reaches BLINK_DIV-1 at a wrap, it SHALL clear and blink phase ph SHALL toggle.
REQ-024 When ph=1 and blink_shadow[idx]=1, the lit cycle SHALL output an=8'hFF and seg=8'hFF.
REQ-025 When zero_blank=1, digits above the highest nonzero nibble SHALL be fully dark (an=8'hFF, seg=8'hFF), point setting ignored.
REQ-026 Digit 0 SHALL never be zero-blanked; a value of 0 shows a single "0".
REQ-027 frame_done SHALL be 1 for exactly the cycle following the edge on which idx wraps 7 to 0.
REQ-028 When blink and zero-blank apply simultaneously, the digit is dark; the blanking conditions are ORed.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set cnt=0, idx=0, frame counter=0, ph=0, value shadow=32'h0, point and blink shadows=8'h00, an=8'hFF, seg=8'hFF and frame_done=0.
REQ-030 rst SHALL override load on the same edge.
REQ-031 Reset asserted mid-frame SHALL restart scanning at digit 0 with a dark cycle.

Verification
REQ-032 Scan order: SCAN_DIV=4, load 32'h76543210, release reset -> an per cycle FF,FE,FE,FE,FF,FD,FD,FD...; seg[6:0] during digit 5 = 7'h12.
REQ-033 Frame and decimal point: point=8'h01 -> seg[7]=0 only while an=FE; frame_done pulses once every 32 cycles, in the cycle after idx wraps.
REQ-034 Zero blank: load 32'h00000A00 with zero_blank=1 -> digits 3..7 dark, digit 2 shows 7'h08, digits 1 and 0 show 7'h40; load 0 -> only digit 0 lit.
REQ-035 Blink: BLINK_DIV=1, blink_en=8'h80 -> digit 7 dark on alternate frames, all other digits lit every frame.
REQ-036 Mid-scan events: load during digit 3 -> no change in cnt or idx, new nibble visible from the next cycle; rst together with load -> shadow stays 0, an=FF.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-segment scanner with per-digit blink, decimal point and leading-zero blanking
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic        load,
  input  logic [7:0]  point,
  input  logic [7:0]  blink_en,
  input  logic        zero_blank,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          ph_q, ph_d;
  logic [31:0]   val_q, val_d;
  logic [7:0]    pt_q, pt_d, bl_q, bl_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic          fd_q, fd_d;
  logic          cnt_end, frm_end, wrap, dark;
  logic [31:0]   upper;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction
  always_comb begin
    cnt_end = cnt_q == CW'(SCAN_DIV - 1);
    wrap    = cnt_end && idx_q == 3'd7;
    frm_end = frm_q == FW'(BLINK_DIV - 1);
    cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q + {2'b00, cnt_end};
    frm_d   = wrap ? (frm_end ? '0 : frm_q + FW'(1)) : frm_q;
    ph_d    = ph_q ^ (wrap & frm_end);
    val_d   = load ? disp_num : val_q;
    pt_d    = load ? point : pt_q;
    bl_d    = load ? blink_en : bl_q;
    // nibbles at and above the current digit; all-zero means this digit is a leading zero
    upper   = val_q >> {idx_q, 2'b00};
    dark    = cnt_q == '0 || (ph_q && bl_q[idx_q]) || (zero_blank && idx_q != 3'd0 && upper == '0);
    an_d    = dark ? 8'hFF : ~(8'b1 << idx_q);
    seg_d   = dark ? 8'hFF : {~pt_q[idx_q], hex7(upper[3:0])};
    fd_d    = wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      frm_q <= '0;
      ph_q  <= 1'b0;
      val_q <= '0;
      pt_q  <= '0;
      bl_q  <= '0;
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      frm_q <= frm_d;
      ph_q  <= ph_d;
      val_q <= val_d;
      pt_q  <= pt_d;
      bl_q  <= bl_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      fd_q  <= fd_d;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench; two instances share stimulus (BLINK_DIV=1 and BLINK_DIV=2)
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, load, zero_blank;
  logic [31:0] disp_num;
  logic [7:0]  point, blink_en;
  logic [7:0]  an, seg, an2, seg2;
  logic        frame_done, fd2;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int         t;
    logic [7:0] an, seg, an2, seg2;
    logic       fd;
    string      nm;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  seg7_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(1)) dut (
    .clk(clk), .rst(rst), .disp_num(disp_num), .load(load), .point(point),
    .blink_en(blink_en), .zero_blank(zero_blank), .an(an), .seg(seg), .frame_done(frame_done)
  );
  seg7_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .disp_num(disp_num), .load(load), .point(point),
    .blink_en(blink_en), .zero_blank(zero_blank), .an(an2), .seg(seg2), .frame_done(fd2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic ex2(input int t, input logic [7:0] a, s, input logic f,
                     input logic [7:0] a2, s2, input string n);
    exp_t x;
    x.t = t; x.an = a; x.seg = s; x.fd = f; x.an2 = a2; x.seg2 = s2; x.nm = n;
    sb.push_back(x);
  endtask
  task automatic ex(input int t, input logic [7:0] a, s, input logic f, input string n);
    ex2(t, a, s, f, a, s, n);
  endtask
  task automatic at(input int t);
    while (cyc < t - 1) begin
      @(posedge clk);
      #2;
    end
  endtask
  always @(negedge clk)
    while (sb.size() != 0 && sb[0].t <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.t != cyc || an !== e.an || seg !== e.seg || frame_done !== e.fd ||
          an2 !== e.an2 || seg2 !== e.seg2 || fd2 !== e.fd) begin
        errors++;
        $display("FAIL %s cyc=%0d tag=%0d: got an=%h seg=%h fd=%b an2=%h seg2=%h fd2=%b, want an=%h seg=%h fd=%b an2=%h seg2=%h",
                 e.nm, cyc, e.t, an, seg, frame_done, an2, seg2, fd2, e.an, e.seg, e.fd, e.an2, e.seg2);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; load = 1'b1; disp_num = 32'hDEADBEEF; point = 8'hFF; blink_en = 8'hFF; zero_blank = 1'b0;
    ex(1, 8'hFF, 8'hFF, 1'b0, "reset_first");
    ex(3, 8'hFF, 8'hFF, 1'b0, "reset_with_load");
    ex(4, 8'hFF, 8'hFF, 1'b0, "d0_dark");
    ex(5, 8'hFE, 8'h40, 1'b0, "d0_lit_dp");
    ex(7, 8'hFE, 8'h40, 1'b0, "d0_last");
    ex(8, 8'hFF, 8'hFF, 1'b0, "d1_dark");
    ex(9, 8'hFD, 8'hF9, 1'b0, "d1_lit");
    ex(25, 8'hDF, 8'h92, 1'b0, "d5_hex5");
    ex(33, 8'h7F, 8'hF8, 1'b0, "d7_lit");
    ex(34, 8'h7F, 8'hF8, 1'b0, "fd_not_yet");
    ex(35, 8'h7F, 8'hF8, 1'b1, "fd_pulse0");
    ex(36, 8'hFF, 8'hFF, 1'b0, "fd_one_cycle");
    ex(37, 8'hFE, 8'h40, 1'b0, "f1_d0");
    ex(65, 8'h7F, 8'hF8, 1'b0, "f1_d7");
    ex(67, 8'h7F, 8'hF8, 1'b1, "fd_pulse1");
    at(4);
    rst = 1'b0; disp_num = 32'h76543210; point = 8'h01; blink_en = 8'h00;
    at(5);
    load = 1'b0;
    ex(81, 8'hF7, 8'hB0, 1'b0, "d3_before_load");
    ex(82, 8'hF7, 8'hB0, 1'b0, "d3_load_edge");
    ex(83, 8'hF7, 8'h90, 1'b0, "d3_new_nibble");
    ex(84, 8'hFF, 8'hFF, 1'b0, "d4_dark_no_restart");
    ex(85, 8'hEF, 8'h99, 1'b0, "d4_lit");
    at(82);
    disp_num = 32'h76549210; load = 1'b1;
    at(83);
    load = 1'b0;
    ex2(97, 8'h7F, 8'hF8, 1'b0, 8'hFF, 8'hFF, "blink_f2_d7");
    ex(125, 8'hBF, 8'h82, 1'b0, "blink_f3_d6");
    ex(129, 8'hFF, 8'hFF, 1'b0, "blink_f3_d7");
    ex(131, 8'hFF, 8'hFF, 1'b1, "blink_f3_end");
    ex(161, 8'h7F, 8'hF8, 1'b0, "blink_f4_d7");
    ex2(193, 8'hFF, 8'hFF, 1'b0, 8'h7F, 8'hF8, "blink_f5_d7");
    ex2(225, 8'h7F, 8'hF8, 1'b0, 8'hFF, 8'hFF, "blink_f6_d7");
    at(93);
    disp_num = 32'h76543210; point = 8'h00; blink_en = 8'h80; load = 1'b1;
    at(94);
    load = 1'b0;
    ex(229, 8'hFE, 8'h40, 1'b0, "zb_d0");
    ex(233, 8'hFD, 8'h40, 1'b0, "zb_d1");
    ex(237, 8'hFB, 8'h08, 1'b0, "zb_d2_A");
    ex(241, 8'hFF, 8'hFF, 1'b0, "zb_d3_dark");
    ex(257, 8'hFF, 8'hFF, 1'b0, "zb_d7_dark");
    ex(259, 8'hFF, 8'hFF, 1'b1, "zb_frame_end");
    ex(273, 8'hF7, 8'h40, 1'b0, "zb_off_live_d3");
    ex(289, 8'h7F, 8'h40, 1'b0, "zb_off_live_d7");
    ex(293, 8'hFE, 8'hC0, 1'b0, "zero_d0");
    ex(297, 8'hFF, 8'hFF, 1'b0, "zero_d1_dark");
    ex(301, 8'hFF, 8'hFF, 1'b0, "zero_d2_dark");
    at(228);
    disp_num = 32'h00000A00; point = 8'hFF; blink_en = 8'h00; zero_blank = 1'b1; load = 1'b1;
    at(229);
    load = 1'b0;
    at(261);
    zero_blank = 1'b0;
    at(292);
    disp_num = 32'h0; point = 8'h00; zero_blank = 1'b1; load = 1'b1;
    at(293);
    load = 1'b0;
    ex(303, 8'hFF, 8'hFF, 1'b0, "midscan_reset");
    ex(304, 8'hFF, 8'hFF, 1'b0, "rst_restart_dark");
    ex(305, 8'hFE, 8'hC0, 1'b0, "rst_restart_d0");
    ex(309, 8'hFF, 8'hFF, 1'b0, "rst_shadow_zero");
    ex(333, 8'hFF, 8'hFF, 1'b0, "rst_d7_dark");
    ex(335, 8'hFF, 8'hFF, 1'b1, "rst_fd_pulse");
    at(303);
    rst = 1'b1; load = 1'b1; disp_num = 32'hFFFFFFFF; point = 8'hFF; blink_en = 8'hFF;
    at(304);
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never reached", sb.size());
      $fatal(1, "drain");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
